// File: rtl/sdram_dm_cache.sv
// ---------------------------------------------------------------------------
// sdram_dm_cache
// Direct-mapped, write-through, no-write-allocate cache of 32-bit words
// placed between the CPU data bus and the SDRAM controller. Read hits are
// answered from the line array. Read misses and all writes go to SDRAM.
// Both buses use valid/ready: the requester holds its request until ready,
// and ready is a single-cycle pulse.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   cpu_addr/din/wmask   CPU request (byte address, write data, byte enables;
//   cpu_valid            wmask == 0 means read)
//   cpu_dout, cpu_ready  CPU response data and one-cycle completion pulse
//   mem_addr/din/wmask   request to the SDRAM controller (word aligned)
//   mem_valid
//   mem_dout, mem_ready  response from the SDRAM controller
//   flush                invalidate every line
//   hit_count/miss_count wrapping read-hit and read-miss counters
// ---------------------------------------------------------------------------
module sdram_dm_cache #(
    parameter int LINES = 256,
    localparam int INDEX_W = $clog2(LINES),
    localparam int TAG_W = 23 - INDEX_W
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [24:0] cpu_addr,
    input  logic [31:0] cpu_din,
    input  logic [3:0]  cpu_wmask,
    input  logic        cpu_valid,
    output logic [31:0] cpu_dout,
    output logic        cpu_ready,
    output logic [24:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [3:0]  mem_wmask,
    output logic        mem_valid,
    input  logic [31:0] mem_dout,
    input  logic        mem_ready,
    input  logic        flush,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    typedef enum logic [1:0] {IDLE, LOOKUP, MEM_WAIT} state_t;

    state_t             r_state;
    state_t             w_stateNext;

    logic [TAG_W-1:0]   r_tagArr  [LINES];
    logic [31:0]        r_dataArr [LINES];
    logic [LINES-1:0]   r_valid;

    logic [22:0]        r_wordAddr;
    logic [31:0]        r_din;
    logic [3:0]         r_wmask;
    logic [TAG_W-1:0]   r_rdTag;
    logic [31:0]        r_rdData;
    logic               r_flushPending;
    logic               r_armed;
    logic               r_cpuReady;
    logic [31:0]        r_cpuDout;
    logic               r_memValid;
    logic [24:0]        r_memAddr;
    logic [31:0]        r_memDin;
    logic [3:0]         r_memWmask;
    logic [31:0]        r_hitCount;
    logic [31:0]        r_missCount;

    logic [INDEX_W-1:0] w_cpuIndex;
    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic               w_isRead;
    logic [31:0]        w_merged;
    logic               w_accept;
    logic               w_clearAll;
    logic               w_fill;
    logic               w_writeHit;
    logic               w_hitInc;
    logic               w_missInc;
    logic               w_flushPendingNext;
    logic               w_armedNext;
    logic               w_cpuReadyNext;
    logic [31:0]        w_cpuDoutNext;
    logic               w_memValidNext;
    logic [24:0]        w_memAddrNext;
    logic [31:0]        w_memDinNext;
    logic [3:0]         w_memWmaskNext;

    // Byte-offset bits never select anything; folded into a sink signal.
    logic               w_unused;
    assign w_unused = ^cpu_addr[1:0];

    assign w_cpuIndex = cpu_addr[INDEX_W+1:2];
    assign w_index    = r_wordAddr[INDEX_W-1:0];
    assign w_tag      = r_wordAddr[22:INDEX_W];
    assign w_isRead   = (r_wmask == 4'b0000);
    // r_rdTag/r_rdData are only meaningful in LOOKUP; the valid bit gates them.
    assign w_hit      = r_valid[w_index] && (r_rdTag == w_tag);

    // Write-hit data: enabled bytes from the CPU, the rest from the cached word.
    always_comb begin
        w_merged = r_rdData;
        for (int b = 0; b < 4; b++) begin
            if (r_wmask[b]) begin
                w_merged[8*b +: 8] = r_din[8*b +: 8];
            end
        end
    end

    // FSM next state plus next values of every registered output.
    always_comb begin
        w_stateNext        = r_state;
        w_accept           = 1'b0;
        w_clearAll         = 1'b0;
        w_fill             = 1'b0;
        w_writeHit         = 1'b0;
        w_hitInc           = 1'b0;
        w_missInc          = 1'b0;
        w_flushPendingNext = r_flushPending | (flush && (r_state != IDLE));
        w_armedNext        = r_armed;
        w_cpuReadyNext     = 1'b0;
        w_cpuDoutNext      = r_cpuDout;
        w_memValidNext     = r_memValid;
        w_memAddrNext      = r_memAddr;
        w_memDinNext       = r_memDin;
        w_memWmaskNext     = r_memWmask;
        case (r_state)
            IDLE: begin
                if (flush || r_flushPending) begin
                    w_clearAll         = 1'b1;
                    w_flushPendingNext = 1'b0;
                end else if (cpu_valid && !r_cpuReady) begin
                    w_accept    = 1'b1;
                    w_stateNext = LOOKUP;
                end
            end
            LOOKUP: begin
                if (w_isRead && w_hit) begin
                    w_cpuReadyNext = 1'b1;
                    w_cpuDoutNext  = r_rdData;
                    w_hitInc       = 1'b1;
                    w_stateNext    = IDLE;
                end else begin
                    w_memValidNext = 1'b1;
                    w_memAddrNext  = {r_wordAddr, 2'b00};
                    w_memWmaskNext = r_wmask;
                    if (!w_isRead) begin
                        w_memDinNext = r_din;
                    end
                    w_armedNext = 1'b0;
                    w_missInc   = w_isRead;
                    w_writeHit  = !w_isRead && w_hit;
                    w_stateNext = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                // A ready seen before the controller ever dropped it is stale
                // (init sequence) and must not complete the access.
                if (!mem_ready) begin
                    w_armedNext = 1'b1;
                end else if (r_armed) begin
                    w_memValidNext = 1'b0;
                    w_cpuReadyNext = 1'b1;
                    if (w_isRead) begin
                        w_cpuDoutNext = mem_dout;
                        w_fill        = 1'b1;
                    end
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid        <= '0;
            r_wordAddr     <= '0;
            r_din          <= '0;
            r_wmask        <= '0;
            r_flushPending <= 1'b0;
            r_armed        <= 1'b0;
            r_cpuReady     <= 1'b0;
            r_cpuDout      <= '0;
            r_memValid     <= 1'b0;
            r_memAddr      <= '0;
            r_memDin       <= '0;
            r_memWmask     <= '0;
            r_hitCount     <= '0;
            r_missCount    <= '0;
        end else begin
            if (w_accept) begin
                r_wordAddr <= cpu_addr[24:2];
                r_din      <= cpu_din;
                r_wmask    <= cpu_wmask;
            end
            if (w_clearAll) begin
                r_valid <= '0;
            end else if (w_fill) begin
                r_valid[w_index] <= 1'b1;
            end
            r_flushPending <= w_flushPendingNext;
            r_armed        <= w_armedNext;
            r_cpuReady     <= w_cpuReadyNext;
            r_cpuDout      <= w_cpuDoutNext;
            r_memValid     <= w_memValidNext;
            r_memAddr      <= w_memAddrNext;
            r_memDin       <= w_memDinNext;
            r_memWmask     <= w_memWmaskNext;
            if (w_hitInc) begin
                r_hitCount <= r_hitCount + 32'd1;
            end
            if (w_missInc) begin
                r_missCount <= r_missCount + 32'd1;
            end
        end
    end

    // Line storage has no reset; the valid bits make stale contents harmless.
    // The array is read on acceptance so LOOKUP compares registered values.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rdTag  <= r_tagArr[w_cpuIndex];
            r_rdData <= r_dataArr[w_cpuIndex];
        end
        if (w_fill) begin
            r_tagArr[w_index]  <= w_tag;
            r_dataArr[w_index] <= mem_dout;
        end else if (w_writeHit) begin
            r_dataArr[w_index] <= w_merged;
        end
    end

    assign cpu_dout   = r_cpuDout;
    assign cpu_ready  = r_cpuReady;
    assign mem_addr   = r_memAddr;
    assign mem_din    = r_memDin;
    assign mem_wmask  = r_memWmask;
    assign mem_valid  = r_memValid;
    assign hit_count  = r_hitCount;
    assign miss_count = r_missCount;

endmodule

// File: doc/sdram_dm_cache.md
Name: sdram_dm_cache

Overview:
- Direct-mapped, write-through, no-write-allocate cache for 32-bit words. It sits between the CPU data bus and the SDRAM controller.
- Both sides use the same valid/ready protocol:
  - The requester holds valid, address and data stable until ready.
  - The responder pulses ready high for exactly one cycle.
  - A new request is accepted only when valid && !ready.
- Read hits are served without touching SDRAM. All writes go through to SDRAM.

Parameters:
- LINES, 256, number of one-word lines; must be a power of 2 and ≥2.
- INDEX_W, $clog2(LINES), index width, derived.
- TAG_W, 23-INDEX_W, tag width, derived from the 25-bit byte address.

Ports:
- clk  in  1  single clock for the whole block
- resetn  in  1  asynchronous active-low reset
- cpu_addr  in  25  byte address; bits [1:0] ignored
- cpu_din  in  32  write data
- cpu_wmask  in  4  byte write enables; 0 = read
- cpu_valid  in  1  request valid
- cpu_dout  out  32  read data
- cpu_ready  out  1  one-cycle completion pulse
- mem_addr  out  25  to controller addr, {cpu_addr[24:2],2'b00}
- mem_din  out  32  to controller din
- mem_wmask  out  4  to controller wmask
- mem_valid  out  1  to controller valid
- mem_dout  in  32  from controller dout
- mem_ready  in  1  from controller ready
- flush  in  1  invalidate all lines
- hit_count  out  32  read-hit counter, wraps
- miss_count  out  32  read-miss counter, wraps

Behaviour:
- Reset (asynchronous on resetn low):
  - state = IDLE; all line valid bits cleared; flush_pending = 0; armed = 0.
  - cpu_ready = 0, cpu_dout = 0, mem_valid = 0, mem_addr = 0, mem_din = 0, mem_wmask = 0, hit_count = 0, miss_count = 0.
  - Reset mid-transaction abandons the transaction. No response is issued.
- Address split:
  - index = cpu_addr[INDEX_W+1:2].
  - tag = cpu_addr[24:INDEX_W+2].
  - Each line stores a tag, a 32-bit word and a valid bit.
- IDLE:
  - If flush or flush_pending: clear all valid bits, clear flush_pending, stay in IDLE. Requests are not accepted that cycle.
  - Else if cpu_valid && !cpu_ready: latch addr, din and wmask; issue the array read; go to LOOKUP.
- LOOKUP (hit = line valid && tag match):
  - Read hit: cpu_dout = stored word; cpu_ready = 1; hit_count += 1; go to IDLE. Latency is 2 cycles from the cycle the request is sampled to cpu_ready high.
  - Read miss: miss_count += 1; mem_valid = 1, mem_wmask = 0, mem_addr = word address; armed = 0; go to MEM_WAIT.
  - Write: mem_valid = 1, mem_wmask = wmask, mem_din = din; armed = 0; go to MEM_WAIT.
    - On a write hit, merge the enabled bytes into the cached word in this cycle.
    - On a write miss, do not allocate.
- MEM_WAIT:
  - mem_valid and the mem_* outputs are held stable.
  - armed is set on the first cycle mem_ready is seen low. mem_ready high while !armed is ignored; this covers the controller holding ready high during its init sequence.
  - On mem_ready && armed: mem_valid = 0 on the next edge; cpu_ready = 1 for one cycle.
    - For a read: cpu_dout = mem_dout, and the line is filled with tag, word and valid = 1.
    - Then go to IDLE.
- cpu_ready is high for exactly one cycle per request. IDLE ignores cpu_valid while cpu_ready = 1.
- flush:
  - flush asserted outside IDLE sets flush_pending. The flush is applied on the next IDLE cycle, after the current request completes.
  - A fill completing in the same transaction is therefore invalidated.
  - flush does not abort an outstanding SDRAM access.
- Counters wrap modulo 2^32. Writes do not count.
- Only one outstanding memory request at a time. No hazards between requests.

Test Plan:
- Controller holds mem_ready = 1 for 50 cycles after reset, then read at 0x0000100 → mem_valid stays high through init; the stale ready pulse is ignored; completion occurs only on the first ready pulse after ready is seen low; cpu_dout = SDRAM word; miss_count = 1.
- Read 0x0000100 twice → second read returns the same data, cpu_ready 2 cycles after acceptance, mem_valid never asserted; hit_count = 1.
- Write 0xAABBCCDD with wmask 4'b0101 to a cached address holding 0x11223344 → SDRAM write issued with mask 4'b0101; a subsequent read hits and returns 0x11BB33DD.
- Conflict: read 0x0000100 then read 0x0000500 (LINES = 256, same index, different tag) → second read misses; then re-reading 0x0000100 misses; miss_count = 3.
- Write miss to uncached 0x0000200, then read 0x0000200 → the write does not allocate; the read misses and returns the written data from SDRAM.
- flush pulsed during a read miss in MEM_WAIT → the read completes normally; the next read of the same address misses; resetn pulsed low mid-MEM_WAIT → mem_valid = 0 and cpu_ready = 0 immediately, and all lines are invalid.
